// File: rtl/control_gen_if.sv
// control_gen_if: ID-stage interface between the decode/hazard unit
// (control_gen) and the surrounding pipeline. The slave modport is the
// control_gen side; the master modport is the pipeline / bench side.
// Optional macro CTRL_PERF_CNT_EN adds the bubble_cnt performance counter.
interface control_gen_if #(
  parameter int CW  = 10,
  parameter int OPW = 6,
  parameter int RW  = 5
);

  // Instruction presented in ID
  logic [OPW-1:0] opcode;
  logic [RW-1:0]  rs;
  logic [RW-1:0]  rt;
  logic           instr_valid;

  // Downstream pipeline control
  logic           hold_in;
  logic           flush;

  // ID/EX control register and hazard outputs
  logic [CW-1:0]  Control;
  logic           ctl_valid;
  logic [RW-1:0]  ex_rt;
  logic           stall;
  logic           illegal;

`ifdef CTRL_PERF_CNT_EN
  logic [15:0]    bubble_cnt;
`endif

  modport slave (
`ifdef CTRL_PERF_CNT_EN
    output bubble_cnt,
`endif
    input  opcode,
    input  rs,
    input  rt,
    input  instr_valid,
    input  hold_in,
    input  flush,
    output Control,
    output ctl_valid,
    output ex_rt,
    output stall,
    output illegal
  );

  modport master (
`ifdef CTRL_PERF_CNT_EN
    input  bubble_cnt,
`endif
    output opcode,
    output rs,
    output rt,
    output instr_valid,
    output hold_in,
    output flush,
    input  Control,
    input  ctl_valid,
    input  ex_rt,
    input  stall,
    input  illegal
  );

endinterface

// File: rtl/control_gen.sv
// control_gen: ID-stage control word generator.
// Decodes the opcode in ID into the 10-bit control word, registers it into
// the ID/EX control register with a valid flag, inserts bubbles on load-use
// hazards, squashes the slot after an unconditional jump and honours
// downstream hold and branch flush.
// Optional macro CTRL_PERF_CNT_EN adds a saturating 16-bit bubble counter
// (hazard and jump-squash bubbles only).
//
// Control bit map:
//   [9] Saltoincond [8] RegDest [7] FuenteALU [6] MemaReg [5] EscrReg
//   [4] LeerMem     [3] EscrMem [2] SaltoCond [1:0] ALUOp
module control_gen #(
  parameter int CW  = 10,
  parameter int OPW = 6,
  parameter int RW  = 5
) (
  input  logic         clk,
  input  logic         reset,
  control_gen_if.slave bus
);

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);

  // Bit position of LeerMem: marks the issued instruction as a load.
  localparam int BIT_MEMREAD = 4;

  typedef enum logic {
    RUN      = 1'b0,
    J_SQUASH = 1'b1
  } state_t;

  // Result of decoding one opcode.
  typedef struct packed {
    logic          illegal;
    logic [CW-1:0] word;
  } dec_t;

  // ID/EX pipeline registers
  logic [CW-1:0] control_p1;
  logic          vld_p1;
  logic [RW-1:0] ex_rt_p1;
  logic          illegal_p1;
  state_t        state_p1;

  // Decode and hazard terms for the instruction in ID
  dec_t          dec_p0;
  logic          rt_used_p0;
  logic          hazard_p0;
  logic          issue_bubble_p0;

  // Opcode -> control word; undecodable opcodes yield a zero word.
  function automatic dec_t decode_op(input logic [OPW-1:0] op);
    dec_t d;
    d.illegal = 1'b0;
    d.word    = '0;
    case (op)
      OP_RTYPE: d.word = CW'(10'h122);
      OP_LW:    d.word = CW'(10'h0F0);
      OP_SW:    d.word = CW'(10'h088);
      OP_BEQ:   d.word = CW'(10'h005);
      OP_J:     d.word = CW'(10'h200);
      OP_ADDI:  d.word = CW'(10'h0A0);
      default:  d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  // Opcodes that read rt as a source operand.
  function automatic logic reads_rt(input logic [OPW-1:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

  // Stage p0: decode, load-use detection and stall request
  always_comb begin
    dec_p0     = decode_op(bus.opcode);
    rt_used_p0 = reads_rt(bus.opcode);
    hazard_p0  = vld_p1 && control_p1[BIT_MEMREAD] && (ex_rt_p1 != '0) &&
                 ((ex_rt_p1 == bus.rs) || (rt_used_p0 && (ex_rt_p1 == bus.rt)));
    // A hazard bubble is only taken from RUN with a real instruction in ID.
    issue_bubble_p0 = (state_p1 == RUN) && bus.instr_valid && hazard_p0;
  end

  // Stall: hold IF/ID on downstream hold or load-use; flush and reset override.
  assign bus.stall = !reset && !bus.flush && (bus.hold_in || issue_bubble_p0);

  // Stage p1: ID/EX control register and jump-squash FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      control_p1 <= '0;
      vld_p1     <= 1'b0;
      ex_rt_p1   <= '0;
      illegal_p1 <= 1'b0;
      state_p1   <= RUN;
    end else if (bus.flush) begin
      control_p1 <= '0;
      vld_p1     <= 1'b0;
      ex_rt_p1   <= '0;
      illegal_p1 <= 1'b0;
      state_p1   <= RUN;
    end else if (bus.hold_in) begin
      control_p1 <= control_p1;
      vld_p1     <= vld_p1;
      ex_rt_p1   <= ex_rt_p1;
      illegal_p1 <= illegal_p1;
      state_p1   <= state_p1;
    end else if (state_p1 == J_SQUASH) begin
      // The slot after a jump is discarded; wait here until it shows up.
      control_p1 <= '0;
      vld_p1     <= 1'b0;
      ex_rt_p1   <= '0;
      illegal_p1 <= 1'b0;
      state_p1   <= bus.instr_valid ? RUN : J_SQUASH;
    end else if (issue_bubble_p0) begin
      control_p1 <= '0;
      vld_p1     <= 1'b0;
      ex_rt_p1   <= '0;
      illegal_p1 <= 1'b0;
      state_p1   <= RUN;
    end else if (bus.instr_valid) begin
      control_p1 <= dec_p0.word;
      vld_p1     <= 1'b1;
      ex_rt_p1   <= bus.rt;
      illegal_p1 <= dec_p0.illegal;
      state_p1   <= (bus.opcode == OP_J) ? J_SQUASH : RUN;
    end else begin
      control_p1 <= '0;
      vld_p1     <= 1'b0;
      ex_rt_p1   <= '0;
      illegal_p1 <= 1'b0;
      state_p1   <= RUN;
    end
  end

  assign bus.Control   = control_p1;
  assign bus.ctl_valid = vld_p1;
  assign bus.ex_rt     = ex_rt_p1;
  assign bus.illegal   = illegal_p1;

`ifdef CTRL_PERF_CNT_EN
  logic [15:0] bubble_cnt_p1;
  logic        count_bubble_p0;

  // Saturating increment: the counter sticks at all-ones.
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Count only bubbles caused by a load-use hazard or a jump squash.
  assign count_bubble_p0 = !bus.flush && !bus.hold_in &&
                           ((state_p1 == J_SQUASH) || issue_bubble_p0);

  // Stage p1: bubble performance counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt_p1 <= '0;
    end else if (count_bubble_p0) begin
      bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
    end
  end

  assign bus.bubble_cnt = bubble_cnt_p1;
`endif

endmodule

// File: tb/tb_control_gen.sv
// tb_control_gen: directed and randomized bench for control_gen with a
// behavioural reference model of the ID-stage control unit.
module tb_control_gen;

  localparam logic [5:0] R    = 6'h00;
  localparam logic [5:0] LW   = 6'h23;
  localparam logic [5:0] SW   = 6'h2B;
  localparam logic [5:0] BEQ  = 6'h04;
  localparam logic [5:0] J    = 6'h02;
  localparam logic [5:0] ADDI = 6'h08;
  localparam logic [5:0] ILL  = 6'h3F;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  control_gen_if bus ();

  control_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: what the ID/EX register should hold, the destination of
  // an in-flight load (0 when none) and whether the next slot is squashed.
  logic [9:0] m_ctrl;
  logic       m_vld;
  logic [4:0] m_rt;
  logic       m_ill;
  logic [4:0] m_load_dest;
  logic       m_squash;
  int         m_cnt;
  logic       obs_stall;

  // The decode table as listed: {illegal, control word}.
  function automatic logic [10:0] spec_word(input logic [5:0] op);
    case (op)
      R:       return {1'b0, 10'h122};
      LW:      return {1'b0, 10'h0F0};
      SW:      return {1'b0, 10'h088};
      BEQ:     return {1'b0, 10'h005};
      J:       return {1'b0, 10'h200};
      ADDI:    return {1'b0, 10'h0A0};
      default: return {1'b1, 10'h000};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl = '0; m_vld = 1'b0; m_rt = '0; m_ill = 1'b0;
    m_load_dest = '0; m_squash = 1'b0; m_cnt = 0;
  endtask

  task automatic model_bubble();
    m_ctrl = '0; m_vld = 1'b0; m_rt = '0; m_ill = 1'b0; m_load_dest = '0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_ctrl"}, 32'(bus.Control), 32'(m_ctrl));
    chk({tag, "_vld"},  32'(bus.ctl_valid), 32'(m_vld));
    chk({tag, "_exrt"}, 32'(bus.ex_rt), 32'(m_rt));
    chk({tag, "_ill"},  32'(bus.illegal), 32'(m_ill));
`ifdef CTRL_PERF_CNT_EN
    chk({tag, "_cnt"},  32'(bus.bubble_cnt), 32'(m_cnt));
`endif
  endtask

  // One ID cycle: present inputs, check stall, clock, check registers.
  task automatic cyc(input logic [5:0] op, input logic [4:0] a, input logic [4:0] b,
                     input logic iv, input logic hd, input logic fl, input string tag);
    logic haz;
    logic exp_stall;
    logic reads;
    logic [10:0] w;
    bus.opcode = op; bus.rs = a; bus.rt = b;
    bus.instr_valid = iv; bus.hold_in = hd; bus.flush = fl;
    #1;
    reads = (op == R) || (op == SW) || (op == BEQ);
    haz = (m_load_dest != 0) && ((m_load_dest == a) || (reads && m_load_dest == b));
    exp_stall = !fl && (hd || (!m_squash && iv && haz));
    obs_stall = bus.stall;
    chk({tag, "_stall"}, 32'(bus.stall), 32'(exp_stall));
    @(posedge clk);
    if (fl) begin
      model_bubble(); m_squash = 1'b0;
    end else if (hd) begin
      // frozen
    end else if (m_squash) begin
      model_bubble();
      if (iv) m_squash = 1'b0;
      if (m_cnt < 65535) m_cnt++;
    end else if (iv && haz) begin
      model_bubble();
      if (m_cnt < 65535) m_cnt++;
    end else if (iv) begin
      w = spec_word(op);
      m_ctrl = w[9:0]; m_ill = w[10]; m_vld = 1'b1; m_rt = b;
      m_load_dest = (op == LW) ? b : 5'd0;
      m_squash = (op == J);
    end else begin
      model_bubble();
    end
    #1;
    check_regs(tag);
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] pool [8];
    pool[0] = R; pool[1] = LW; pool[2] = SW; pool[3] = BEQ;
    pool[4] = J; pool[5] = ADDI; pool[6] = ILL; pool[7] = 6'($urandom);
    return pool[$urandom_range(0, 7)];
  endfunction

  initial begin
    // Reset state; hold_in asserted to show stall stays low under reset.
    reset = 1'b1;
    bus.opcode = R; bus.rs = 5'd1; bus.rt = 5'd2;
    bus.instr_valid = 1'b1; bus.hold_in = 1'b1; bus.flush = 1'b0;
    #12;
    chk("rst_ctrl", 32'(bus.Control), 32'h0);
    chk("rst_vld", 32'(bus.ctl_valid), 32'h0);
    chk("rst_exrt", 32'(bus.ex_rt), 32'h0);
    chk("rst_ill", 32'(bus.illegal), 32'h0);
    chk("rst_stall", 32'(bus.stall), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Issue sequence without conflicts
    cyc(R,    5'd1,  5'd2,  1, 0, 0, "iss_r");    chk("iss_r_k", 32'(bus.Control), 32'h122);
    cyc(LW,   5'd5,  5'd6,  1, 0, 0, "iss_lw");   chk("iss_lw_k", 32'(bus.Control), 32'h0F0);
    cyc(SW,   5'd7,  5'd8,  1, 0, 0, "iss_sw");   chk("iss_sw_k", 32'(bus.Control), 32'h088);
    cyc(BEQ,  5'd9,  5'd10, 1, 0, 0, "iss_beq");  chk("iss_beq_k", 32'(bus.Control), 32'h005);
    cyc(ADDI, 5'd11, 5'd12, 1, 0, 0, "iss_addi"); chk("iss_addi_k", 32'(bus.Control), 32'h0A0);

    // Load-use via rs
    cyc(LW, 5'd1, 5'd3, 1, 0, 0, "lu_lw");
    cyc(R,  5'd3, 5'd2, 1, 0, 0, "lu_rs");
    chk("lu_rs_stall_k", 32'(obs_stall), 32'h1);
    chk("lu_rs_bub_k", 32'(bus.Control), 32'h0);
    cyc(R,  5'd3, 5'd2, 1, 0, 0, "lu_rs2");
    chk("lu_rs2_k", 32'(bus.Control), 32'h122);
    cyc(LW, 5'd1, 5'd0, 1, 0, 0, "lu_z_lw");
    cyc(R,  5'd0, 5'd2, 1, 0, 0, "lu_z");
    chk("lu_z_stall_k", 32'(obs_stall), 32'h0);

    // Load-use via rt
    cyc(LW,   5'd1, 5'd4, 1, 0, 0, "lt_lw");
    cyc(SW,   5'd2, 5'd4, 1, 0, 0, "lt_sw");
    chk("lt_sw_stall_k", 32'(obs_stall), 32'h1);
    cyc(SW,   5'd2, 5'd4, 1, 0, 0, "lt_sw2");
    cyc(LW,   5'd1, 5'd4, 1, 0, 0, "lt_lw2");
    cyc(ADDI, 5'd1, 5'd4, 1, 0, 0, "lt_addi");
    chk("lt_addi_stall_k", 32'(obs_stall), 32'h0);
    chk("lt_addi_k", 32'(bus.Control), 32'h0A0);

    // Jump squash
    cyc(J,    5'd0, 5'd0, 1, 0, 0, "js_j");
    chk("js_j_k", 32'(bus.Control), 32'h200);
    cyc(ADDI, 5'd1, 5'd2, 1, 0, 0, "js_sq");
    chk("js_sq_k", 32'(bus.ctl_valid), 32'h0);
    cyc(ADDI, 5'd1, 5'd2, 1, 0, 0, "js_run");
    chk("js_run_k", 32'(bus.Control), 32'h0A0);

    // Flush with hazard, flush with hold, hold for three cycles
    cyc(LW, 5'd1, 5'd5, 1, 0, 0, "fh_lw");
    cyc(R,  5'd5, 5'd2, 1, 0, 1, "fh_fl");
    chk("fh_stall_k", 32'(obs_stall), 32'h0);
    cyc(ADDI, 5'd1, 5'd2, 1, 0, 0, "fo_addi");
    cyc(R,    5'd1, 5'd2, 1, 1, 1, "fo_fl");
    chk("fo_k", 32'(bus.Control), 32'h0);
    cyc(BEQ, 5'd1, 5'd2, 1, 0, 0, "hd_beq");
    for (int i = 0; i < 3; i++) begin
      cyc(R, 5'd1, 5'd2, 1, 1, 0, "hd");
      chk("hd_stall_k", 32'(obs_stall), 32'h1);
      chk("hd_k", 32'(bus.Control), 32'h005);
    end
    cyc(R, 5'd1, 5'd2, 1, 0, 0, "hd_rel");

    // Illegal opcode
    cyc(ILL, 5'd1, 5'd2, 1, 0, 0, "ill");
    chk("ill_k", 32'(bus.illegal), 32'h1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(pick_op(), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 19) == 0), "rnd");
    end

    // Reset mid-stream between edges, from J_SQUASH with live outputs
    cyc(J, 5'd0, 5'd7, 1, 0, 0, "mr_j");
    #3;
    reset = 1'b1;
    bus.hold_in = 1'b1;
    #1;
    chk("mr_ctrl", 32'(bus.Control), 32'h0);
    chk("mr_vld", 32'(bus.ctl_valid), 32'h0);
    chk("mr_exrt", 32'(bus.ex_rt), 32'h0);
    chk("mr_stall", 32'(bus.stall), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    cyc(ADDI, 5'd1, 5'd2, 1, 0, 0, "mr_run");
    chk("mr_run_k", 32'(bus.Control), 32'h0A0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
